serial_host_streamer: RTL
=========================

Name: serial_host_streamer

Overview:
- Host-side initiator for the console replay serial protocol. It plays the role the PC normally plays.
- Drives a UART TX/RX byte pair toward the replay board's serial handler: reset handshake, setup handshake, frame prebuffer, then request-driven streaming.
- Frames come from a synchronous-read frame memory.
- Used for standalone ROM-driven replay and as a loopback bench driver.

Parameters:
ADDR_W, 16, frame-memory address width; max frames is 2^ADDR_W-1
PREBUFFER_FRAMES, 64, frames sent unsolicited before streaming begins
RESP_TIMEOUT, 40000, clk cycles allowed for an expected response byte
RESP_WINDOW, 20000, clk cycles after a frame's last byte to watch for an overrun reply

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a session when idle
frame_count  in  ADDR_W  number of frames to play, sampled on start
tx_dv  out  1  one-cycle strobe: send tx_byte
tx_byte  out  8  byte to transmit
tx_done  in  1  one-cycle pulse when the UART finishes a byte
rx_dv  in  1  one-cycle strobe: rx_byte valid
rx_byte  in  8  received byte
rd_en  out  1  frame-memory read strobe
frame_addr  out  ADDR_W  frame-memory address
frame_data  in  32  read data, valid 1 cycle after rd_en
busy  out  1  session in progress
done  out  1  all frames accepted
error  out  1  session aborted
error_code  out  8  abort cause
frames_sent  out  ADDR_W  committed (accepted) frame count

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; counters 0; pending_req 0.
  - Reset mid-session aborts immediately, with no trailing bytes.
- Byte send rule:
  - Pulse tx_dv for 1 cycle with tx_byte.
  - The next tx_dv waits for tx_done.
  - Never two bytes in flight.
- IDLE:
  - On start: latch frame_count, clear done/error/frames_sent, set busy, go to RST_SEND.
  - start while busy is ignored.
- RST_SEND: send 0x52 ('R'), then go to RST_WAIT1.
- RST_WAIT1 / RST_WAIT2:
  - Expect 0x01, then 0x52.
  - Then go to SETUP_SEND.
- SETUP_SEND:
  - Send 0x53, 0x41, 0x4D, 0x80, 0x00 in order.
  - Then go to SETUP_WAIT1.
- SETUP_WAIT1 / SETUP_WAIT2:
  - Expect 0x01, then 0x53.
  - Then go to FETCH, with phase=PREBUF.
- Response timeout:
  - Every WAIT state runs a timeout counter, cleared on state entry.
  - On reaching RESP_TIMEOUT: go to ERROR with code 0xE1.
- Unexpected byte in a WAIT state: go to ERROR with code = rx_byte.
  - Exception: 0x41 is never an error outside WAIT states (see pending_req).
- FETCH:
  - If frames_sent == latched frame_count: go to DONE.
  - Else: frame_addr = frames_sent, pulse rd_en, capture frame_data next cycle, go to FRAME_SEND.
- FRAME_SEND:
  - Send 0x41, then frame bits [31:24], [23:16], [15:8], [7:0].
  - After the last tx_done: go to FRAME_WIN.
- FRAME_WIN (window counter, RESP_WINDOW cycles):
  - rx 0xB0 (overrun):
    - frames_sent unchanged (same frame resent later).
    - phase = STREAM.
    - Go to STREAM_WAIT.
  - rx 0xFF / 0xFE: go to ERROR with code = byte.
  - rx 0x41: set pending_req, keep waiting.
  - Window expiry: frames_sent += 1 (commit).
    - If phase=PREBUF and the count of frames sent this phase reaches PREBUFFER_FRAMES: phase = STREAM.
    - Go to FETCH if phase=PREBUF, else STREAM_WAIT.
- STREAM_WAIT:
  - If pending_req, or rx 0x41 this cycle: clear pending_req, go to FETCH.
  - No timeout in this state; the console may stall indefinitely.
- rx 0x41 in any non-WAIT state: sets pending_req. Only one request is held.
- DONE:
  - done=1, busy=0. Hold until the next start.
  - frame_count==0 enters DONE straight after setup.
- ERROR:
  - error=1, busy=0, error_code held. Hold until start or reset.
- Widths:
  - frames_sent saturates at frame_count; no wrap.
  - The timeout counter is sized for max(RESP_TIMEOUT, RESP_WINDOW).

Optional Feature:
SERIAL_HOST_PING_EN
- Defined:
  - In STREAM_WAIT, after 2*RESP_TIMEOUT idle cycles with no 0x41, send 0xAA and go to PING_WAIT.
  - PING_WAIT expects 0x55 within RESP_TIMEOUT, then returns to STREAM_WAIT.
  - 0x41 arriving in PING_WAIT sets pending_req.
  - Timeout: go to ERROR with code 0xE2.
- Undefined: no ping logic; STREAM_WAIT waits forever.

Test Plan:
- Reset then start (frame_count=3, PREBUFFER_FRAMES=64), bench device answers correctly → TX stream: 52; 53 41 4D 80 00; three frames each 41+4 bytes MSB first; done=1, frames_sent=3.
- Device answers 0xB0 during the 2nd prebuffer frame window → frame 1 resent only after the next 0x41; frames_sent counts 1→2 only after a clean window.
- Device silent after 'R' → after RESP_TIMEOUT cycles error=1, error_code=0xE1, busy=0.
- Device replies 0xFE to setup → error_code=0xFE, no further tx_dv.
- 0x41 arrives during FRAME_SEND in STREAM phase → pending_req set; next frame fetched without waiting for another 0x41.
- Reset asserted mid-frame (after 2 data bytes) → all outputs 0 next cycle, no further tx_dv; new start performs full R/S sequence.

Source files
------------

// File: rtl/serial_host_streamer_if.sv
// rtl/serial_host_streamer_if.sv - UART byte pair and frame-memory read port of the serial host streamer
// Signals:
//   tx_dv/tx_byte   : host -> UART, one-cycle send strobe and byte
//   tx_done         : UART -> host, one-cycle pulse when the byte has left
//   rx_dv/rx_byte   : UART -> host, one-cycle receive strobe and byte
//   rd_en/frame_addr: host -> memory, read strobe and frame index
//   frame_data      : memory -> host, valid one cycle after rd_en
// Modports: master = the streamer, slave = the UART / memory side.
interface serial_host_streamer_if #(
    parameter int ADDR_W = 16
);
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              rd_en;
    logic [ADDR_W-1:0] frame_addr;
    logic [31:0]       frame_data;

    modport master (
        output tx_dv, tx_byte, rd_en, frame_addr,
        input  tx_done, rx_dv, rx_byte, frame_data
    );

    modport slave (
        input  tx_dv, tx_byte, rd_en, frame_addr,
        output tx_done, rx_dv, rx_byte, frame_data
    );
endinterface

// File: rtl/serial_host_streamer.sv
// rtl/serial_host_streamer.sv - host-side initiator for the console replay serial protocol
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : one-cycle pulse, begins a session when not busy
//   frame_count      : number of frames to play, sampled on start
//   bus (master)     : UART tx/rx byte pair and frame-memory read port
//   busy/done/error  : session status; error_code holds the abort cause
//   frames_sent      : frames accepted by the device
// Optional feature macro SERIAL_HOST_PING_EN: ping the device (0xAA, expect 0x55)
// after a long request-free stall in STREAM_WAIT.
module serial_host_streamer #(
    parameter int ADDR_W           = 16,
    parameter int PREBUFFER_FRAMES = 64,
    parameter int RESP_TIMEOUT     = 40000,
    parameter int RESP_WINDOW      = 20000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     frame_count,
    serial_host_streamer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            error_code,
    output logic [ADDR_W-1:0]     frames_sent
);
    localparam int T_MAX = (RESP_TIMEOUT > RESP_WINDOW) ? RESP_TIMEOUT : RESP_WINDOW;
`ifdef SERIAL_HOST_PING_EN
    localparam int CNT_MAX = (2 * RESP_TIMEOUT > T_MAX) ? 2 * RESP_TIMEOUT : T_MAX;
`else
    localparam int CNT_MAX = T_MAX;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(RESP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(RESP_WINDOW - 1);
    localparam logic [ADDR_W-1:0] PB_LAST  = ADDR_W'(PREBUFFER_FRAMES - 1);
`ifdef SERIAL_HOST_PING_EN
    localparam logic [CNT_W-1:0]  PING_LAST = CNT_W'(2 * RESP_TIMEOUT - 1);
`endif

    typedef enum logic [4:0] {
        ST_IDLE, ST_RST_SEND, ST_RST_WAIT1, ST_RST_WAIT2,
        ST_SETUP_SEND, ST_SETUP_WAIT1, ST_SETUP_WAIT2,
        ST_FETCH, ST_FETCH_RD, ST_FETCH_CAP, ST_FRAME_SEND, ST_FRAME_WIN,
        ST_STREAM_WAIT, ST_PING_SEND, ST_PING_WAIT, ST_DONE, ST_ERROR
    } state_t;

    state_t            state, state_n, wait_next, send_next;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        idx;
    logic              in_flight, tx_dv_r, rd_en_r, phase_stream, pending;
    logic [7:0]        tx_byte_r, send_byte, exp_byte, err_n;
    logic [ADDR_W-1:0] addr_r, fcount;
    logic [31:0]       frame_r;
    logic              counting, is_send, is_wait, send_last, issue_rd, commit;
    logic              enter_stream, take_req, set_pend, start_go, go_err;
    logic              byte_ack, rx_req;

    assign byte_ack = in_flight && bus.tx_done;
    assign rx_req   = bus.rx_dv && (bus.rx_byte == 8'h41);

    assign bus.tx_dv      = tx_dv_r;
    assign bus.tx_byte    = tx_byte_r;
    assign bus.rd_en      = rd_en_r;
    assign bus.frame_addr = addr_r;
    assign busy  = !(state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign done  = (state == ST_DONE);
    assign error = (state == ST_ERROR);

    always_comb begin
        state_n = state;   wait_next = state;  send_next = state;
        counting = 1'b0;   is_send = 1'b0;     is_wait = 1'b0;
        send_byte = 8'h00; send_last = 1'b0;   exp_byte = 8'h00;
        issue_rd = 1'b0;   commit = 1'b0;      enter_stream = 1'b0;
        take_req = 1'b0;   start_go = 1'b0;    go_err = 1'b0;
        err_n = 8'h00;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    start_go = 1'b1;
                    state_n  = ST_RST_SEND;
                end
            end
            ST_RST_SEND: begin
                is_send = 1'b1; send_byte = 8'h52; send_last = 1'b1; send_next = ST_RST_WAIT1;
            end
            ST_RST_WAIT1:   begin is_wait = 1'b1; exp_byte = 8'h01; wait_next = ST_RST_WAIT2;   end
            ST_RST_WAIT2:   begin is_wait = 1'b1; exp_byte = 8'h52; wait_next = ST_SETUP_SEND;  end
            ST_SETUP_SEND: begin
                is_send = 1'b1; send_last = (idx == 3'd4); send_next = ST_SETUP_WAIT1;
                case (idx)
                    3'd0:    send_byte = 8'h53;
                    3'd1:    send_byte = 8'h41;
                    3'd2:    send_byte = 8'h4D;
                    3'd3:    send_byte = 8'h80;
                    default: send_byte = 8'h00;
                endcase
            end
            ST_SETUP_WAIT1: begin is_wait = 1'b1; exp_byte = 8'h01; wait_next = ST_SETUP_WAIT2; end
            ST_SETUP_WAIT2: begin is_wait = 1'b1; exp_byte = 8'h53; wait_next = ST_FETCH;       end
            ST_FETCH: begin
                if (frames_sent == fcount) begin
                    state_n = ST_DONE;
                end else begin
                    issue_rd = 1'b1;
                    state_n  = ST_FETCH_RD;
                end
            end
            // Memory sees rd_en in FETCH_RD; its data is captured on leaving FETCH_CAP.
            ST_FETCH_RD:  state_n = ST_FETCH_CAP;
            ST_FETCH_CAP: state_n = ST_FRAME_SEND;
            ST_FRAME_SEND: begin
                is_send = 1'b1; send_last = (idx == 3'd4); send_next = ST_FRAME_WIN;
                case (idx)
                    3'd0:    send_byte = 8'h41;
                    3'd1:    send_byte = frame_r[31:24];
                    3'd2:    send_byte = frame_r[23:16];
                    3'd3:    send_byte = frame_r[15:8];
                    default: send_byte = frame_r[7:0];
                endcase
            end
            ST_FRAME_WIN: begin
                counting = 1'b1;
                if (bus.rx_dv && bus.rx_byte == 8'hB0) begin
                    // Overrun: the frame is not committed and is resent on the next request.
                    enter_stream = 1'b1;
                    state_n      = ST_STREAM_WAIT;
                end else if (bus.rx_dv && (bus.rx_byte == 8'hFF || bus.rx_byte == 8'hFE)) begin
                    go_err = 1'b1;
                    err_n  = bus.rx_byte;
                end else if (cnt == WIN_LAST) begin
                    commit = 1'b1;
                    if (phase_stream || frames_sent == PB_LAST) begin
                        enter_stream = 1'b1;
                        state_n      = ST_STREAM_WAIT;
                    end else begin
                        state_n = ST_FETCH;
                    end
                end
            end
            ST_STREAM_WAIT: begin
                if (pending || rx_req) begin
                    take_req = 1'b1;
                    state_n  = ST_FETCH;
                end
`ifdef SERIAL_HOST_PING_EN
                else begin
                    counting = 1'b1;
                    if (cnt == PING_LAST) state_n = ST_PING_SEND;
                end
`endif
            end
`ifdef SERIAL_HOST_PING_EN
            ST_PING_SEND: begin
                is_send = 1'b1; send_byte = 8'hAA; send_last = 1'b1; send_next = ST_PING_WAIT;
            end
            ST_PING_WAIT: begin
                counting = 1'b1;
                if (bus.rx_dv) begin
                    if (bus.rx_byte == 8'h55) begin
                        state_n = ST_STREAM_WAIT;
                    end else if (bus.rx_byte != 8'h41) begin
                        go_err = 1'b1;
                        err_n  = bus.rx_byte;
                    end
                end else if (cnt == TO_LAST) begin
                    go_err = 1'b1;
                    err_n  = 8'hE2;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase

        if (is_send && byte_ack && send_last) state_n = send_next;

        if (is_wait) begin
            counting = 1'b1;
            if (bus.rx_dv) begin
                if (bus.rx_byte == exp_byte) begin
                    state_n = wait_next;
                end else begin
                    go_err = 1'b1;
                    err_n  = bus.rx_byte;
                end
            end else if (cnt == TO_LAST) begin
                go_err = 1'b1;
                err_n  = 8'hE1;
            end
        end

        // A request outside the handshake waits is remembered for STREAM_WAIT.
        set_pend = rx_req && busy && !is_wait && (state != ST_STREAM_WAIT);

        if (go_err) state_n = ST_ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;  cnt <= '0;        idx <= '0;        in_flight <= 1'b0;
            tx_dv_r <= 1'b0;   tx_byte_r <= '0;  rd_en_r <= 1'b0;  addr_r <= '0;
            frame_r <= '0;     fcount <= '0;     frames_sent <= '0;
            error_code <= '0;  phase_stream <= 1'b0; pending <= 1'b0;
        end else begin
            state <= state_n;

            if (state_n != state || !counting) cnt <= '0;
            else                               cnt <= cnt + 1'b1;

            // One byte in flight at a time: tx_dv is raised only when the previous tx_done has landed.
            tx_dv_r <= 1'b0;
            if (state_n != state) begin
                idx       <= '0;
                in_flight <= 1'b0;
            end else if (is_send && !in_flight) begin
                in_flight <= 1'b1;
                tx_dv_r   <= 1'b1;
                tx_byte_r <= send_byte;
            end else if (byte_ack) begin
                in_flight <= 1'b0;
                idx       <= idx + 1'b1;
            end

            rd_en_r <= issue_rd;
            if (issue_rd) addr_r <= frames_sent;
            if (state == ST_FETCH_CAP) frame_r <= bus.frame_data;

            if (start_go) begin
                fcount       <= frame_count;
                frames_sent  <= '0;
                error_code   <= '0;
                phase_stream <= 1'b0;
            end else begin
                if (commit && frames_sent != fcount) frames_sent <= frames_sent + 1'b1;
                if (enter_stream) phase_stream <= 1'b1;
                if (go_err) error_code <= err_n;
            end

            if (start_go || take_req) pending <= 1'b0;
            else if (set_pend)        pending <= 1'b1;
        end
    end
endmodule
